// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer
//   Upstream feeder for the SPI master. Bytes from a producer are buffered in
//   a DEPTH-entry FIFO and handed to the master one at a time. Each byte gets
//   a one-cycle start pulse. The sequencer then waits for the master's done
//   strobe and idles for GAP_CYCLES clocks before loading the next byte.
//
//   Ports
//     clk          system clock, rising edge
//     reset_n      asynchronous active-low reset
//     s_data       byte from producer
//     s_valid      s_data valid
//     s_ready      FIFO can accept (= !full), combinational
//     spi_data_out byte presented to the master, registered at LOAD
//     spi_tx_start one-cycle start pulse to the master
//     spi_tx_done  done strobe from the master, honoured only in WAIT
//     fifo_level   FIFO occupancy, 0..DEPTH
//     busy         FSM not idle or FIFO not empty
//     timeout_err  sticky WAIT timeout flag
//
//   Build option
//     SPI_SEQ_TIMEOUT_EN : when defined, WAIT gives up after TIMEOUT clocks
//                          without spi_tx_done, drops the byte, sets
//                          timeout_err and moves on. When undefined, WAIT
//                          holds indefinitely and timeout_err is tied 0.
module spi_tx_sequencer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [7:0]      spi_data_out,
  output logic            spi_tx_start,
  input  logic            spi_tx_done,
  output logic [ADDR_W:0] fifo_level,
  output logic            busy,
  output logic            timeout_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

  if (DEPTH < 2 || DEPTH != (1 << ADDR_W) || TIMEOUT < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("spi_tx_sequencer: illegal DEPTH/ADDR_W/TIMEOUT/GAP_CYCLES combination");
  end

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              full, empty, push, pop;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_last;
  logic              tmo_hit;

  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign s_ready    = !full;
  // A push is refused whenever the FIFO is full, even if LOAD pops in the
  // same cycle; the producer keeps s_valid high and lands on the next edge.
  assign push       = s_valid && !full;
  assign pop        = (state == LOAD);
  assign fifo_level = level;
  assign busy       = (state != IDLE) || !empty;
  assign gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // ---- FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // ---- FIFO pointers and occupancy ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---- Optional WAIT timeout ----
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  // A done arriving on the same edge as the timeout wins.
  assign tmo_hit = (state == WAIT) && !spi_tx_done &&
                   (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT)  tmo_cnt <= '0;
      else if (!tmo_hit)  tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---- Inter-byte gap counter ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           gap_cnt <= '0;
    else if (state != GAP)  gap_cnt <= '0;
    else                    gap_cnt <= gap_cnt + 1'b1;
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (spi_tx_done || tmo_hit) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM state register and master-facing outputs ----
  // spi_tx_start is registered from LOAD so it is high exactly while the
  // FSM sits in START; spi_data_out is captured at the LOAD edge and holds
  // until the next LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      spi_tx_start <= 1'b0;
      spi_data_out <= '0;
    end else begin
      state        <= state_nxt;
      spi_tx_start <= (state == LOAD);
      if (pop) spi_data_out <= mem[rd_ptr];
    end
  end

endmodule
